shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised successor to the single-bit d_latch/dff primitives: a WIDTH-bit universal shift register built from synchronously reset D flip-flops.
- Supports hold, parallel load, shift left/right, rotate left/right and clear.
- Adds a burst-serialise mode: a counter-driven FSM shifts out exactly WIDTH bits on sout, then pulses done.
- Used as the serialiser/deserialiser register in later lab datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal values are WIDTH >= 2.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- MSB_FIRST, 1, burst direction: 1 = shift left (MSB out first), 0 = shift right (LSB out first).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, reset; synchronous, active-high.
- en, input, 1, clock enable; 0 freezes all state, including the burst FSM.
- mode, input, 3, command: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110 BURST, 111 CLEAR.
- pin, input, WIDTH, parallel load data.
- sin, input, 1, serial input bit.
- q, output, WIDTH, register contents (registered).
- sout, output, 1, serial output: q[WIDTH-1] if MSB_FIRST=1, else q[0]. Combinational from q.
- busy, output, 1, burst in progress (registered).
- done, output, 1, one-cycle pulse at burst completion (registered).
- cnt, output, $clog2(WIDTH), burst bit index (registered).

Behaviour:
- Reset:
  - Decided interface fact: one clock; reset is synchronous and active-high.
  - On an edge with rst=1: q=RST_VAL, busy=0, done=0, cnt=0.
  - rst has priority over en and mode.
- Priority at each edge: rst > (en==0: hold everything, done<=0) > CLEAR > busy burst > mode command.
- done is 0 by default every edge unless the completion condition below applies.
- Commands, evaluated only when busy=0:
  - HOLD: q unchanged.
  - LOAD: q<=pin.
  - SHL: q<={q[W-2:0],sin}.
  - SHR: q<={sin,q[W-1:1]}.
  - ROTL: q<={q[W-2:0],q[W-1]}.
  - ROTR: q<={q[0],q[W-1:1]}.
  - BURST: busy<=1, cnt<=0, q unchanged at this edge.
  - CLEAR: q<=0.
- FSM states: IDLE (busy=0) and SHIFT (busy=1).
  - IDLE -> SHIFT on BURST with en=1.
  - In SHIFT, each edge with en=1 and mode!=CLEAR:
    - Shifts q in the MSB_FIRST direction, taking sin.
    - If cnt==WIDTH-1: busy<=0, done<=1, cnt<=0. Otherwise cnt<=cnt+1.
  - SHIFT -> IDLE on CLEAR (abort): q<=0, busy<=0, cnt<=0, done stays 0.
  - While busy, all modes other than CLEAR are ignored.
- Latency and serial timing:
  - With en held at 1, busy is high for exactly WIDTH cycles.
  - sout during the k-th busy cycle (k=0..WIDTH-1) is bit k of the loaded word in burst order, so the receiver samples sout on each edge where busy=1.
  - done is high in the cycle immediately after the last busy cycle.
- en=0 mid-burst: the burst stretches; no bit is lost or repeated; busy stays high.
- BURST issued in the done cycle: accepted (busy=0 in that cycle); done still pulses for that one cycle.
- After a burst, q holds the WIDTH sin bits shifted in, giving SIPO capture for free.
- cnt increments by 1 per shift and wraps to 0 only at completion; no overflow state is reachable.

Decomposition:
- Package shift_pkg: 3-bit localparams MODE_HOLD through MODE_CLEAR, plus a state enum {ST_IDLE, ST_SHIFT}.
- Single module. An optional sub-module burst_ctr (cnt, busy, done generation) is natural if reused. The datapath stays inline.

Test Plan (WIDTH=8, RST_VAL=0, MSB_FIRST=1 unless noted):
- rst=1 for 1 edge after LOAD 0xFF, with en=0 -> q=0x00, busy=0, done=0, cnt=0.
- LOAD 0xA5 then, each starting from 0xA5:
  - SHL with sin=1 -> 0x4B.
  - SHR with sin=0 -> 0x52.
  - ROTL -> 0x4B.
  - ROTR -> 0xD2.
  - CLEAR -> 0x00.
- LOAD 0xA5, BURST, sin=0 -> sout=1,0,1,0,0,1,0,1 over 8 busy cycles; done=1 in cycle 9; q=0x00. With MSB_FIRST=0 -> sout=1,0,1,0,0,1,0,1 (LSB first).
- Burst of 0x3C with en=0 for 3 cycles at cnt=4 -> busy high 11 cycles; bit sequence 0,0,1,1,1,1,0,0 unchanged; LOAD 0xFF issued while busy is ignored.
- CLEAR at cnt=3 mid-burst -> next cycle q=0, busy=0, done never asserted. A subsequent BURST with sin=1 ends with q=0xFF.
- rst=1 with en=0 at cnt=5 mid-burst -> q=0x00, busy=0, cnt=0, no done pulse.

Source files
------------

// File: rtl/shift_reg_univ_pkg.sv
// Shared command encodings and burst FSM state type for the universal shift register.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_BURST = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Command/data bundle of the universal shift register; master drives commands,
// slave (the register) returns contents and burst status.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8
) ();

  localparam int CW = $clog2(WIDTH);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] pin;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;
  logic [CW-1:0]    cnt;

  modport master (
    output en, mode, pin, sin,
    input  q, sout, busy, done, cnt
  );

  modport slave (
    input  en, mode, pin, sin,
    output q, sout, busy, done, cnt
  );

endinterface

// File: rtl/shift_reg_univ_burst_ctr.sv
// Burst sequencer: tracks IDLE/SHIFT, counts shifted bits and pulses done
// after the last one. A CLEAR aborts a burst silently.
module shift_reg_univ_burst_ctr
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt,
  output logic          shift_en
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          done_reg, done_next;

  // State, counter and done pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: en=0 freezes everything except that done falls back to 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    if (en) begin
      if (mode == MODE_CLEAR) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (mode == MODE_BURST) begin
              state_next = ST_SHIFT;
              cnt_next   = '0;
            end
          end
          ST_SHIFT: begin
            if (cnt_reg == LAST_IDX) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
              done_next  = 1'b1;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state_reg == ST_SHIFT);
  assign done     = done_reg;
  assign cnt      = cnt_reg;
  // The datapath shifts on exactly the edges where the counter advances.
  assign shift_en = busy && en && (mode != MODE_CLEAR);

endmodule

// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/clear commands
// plus a counted burst that serialises the word on sout while capturing sin.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter bit               MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  shift_reg_univ_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] burst_q;
  logic             busy;
  logic             done;
  logic [CW-1:0]    cnt;
  logic             shift_en;

  shift_reg_univ_burst_ctr #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_burst_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .mode     (bus.mode),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt),
    .shift_en (shift_en)
  );

  // Burst direction is fixed at elaboration; sout is always the bit leaving next.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign burst_q  = {q_reg[WIDTH-2:0], bus.sin};
      assign bus.sout = q_reg[WIDTH-1];
    end else begin : g_lsb_first
      assign burst_q  = {bus.sin, q_reg[WIDTH-1:1]};
      assign bus.sout = q_reg[0];
    end
  endgenerate

  // Data register with synchronous reset to RST_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= RST_VAL;
    end else begin
      q_reg <= q_next;
    end
  end

  // Next contents: CLEAR wins, then an active burst, then the idle command set.
  always_comb begin
    q_next = q_reg;
    if (bus.en) begin
      if (bus.mode == MODE_CLEAR) begin
        q_next = '0;
      end else if (shift_en) begin
        q_next = burst_q;
      end else if (!busy) begin
        case (bus.mode)
          MODE_HOLD:  q_next = q_reg;
          MODE_LOAD:  q_next = bus.pin;
          MODE_SHL:   q_next = {q_reg[WIDTH-2:0], bus.sin};
          MODE_SHR:   q_next = {bus.sin, q_reg[WIDTH-1:1]};
          MODE_ROTL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          MODE_ROTR:  q_next = {q_reg[0], q_reg[WIDTH-1:1]};
          MODE_BURST: q_next = q_reg;
          default:    q_next = q_reg;
        endcase
      end
    end
  end

  assign bus.q    = q_reg;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.cnt  = cnt;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a word-level model.
module tb_shift_reg_univ;
  import shift_pkg::*;

  localparam int W = 8;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         en   = 1'b0;
  logic         sin  = 1'b0;
  logic [2:0]   mode = MODE_HOLD;
  logic [W-1:0] pin  = '0;

  shift_reg_univ_if #(.WIDTH(W)) if_m ();
  shift_reg_univ_if #(.WIDTH(W)) if_l ();

  assign if_m.en   = en;
  assign if_m.mode = mode;
  assign if_m.pin  = pin;
  assign if_m.sin  = sin;
  assign if_l.en   = en;
  assign if_l.mode = mode;
  assign if_l.pin  = pin;
  assign if_l.sin  = sin;

  shift_reg_univ #(.WIDTH(W), .RST_VAL(8'h00), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk), .rst (rst), .bus (if_m)
  );
  shift_reg_univ #(.WIDTH(W), .RST_VAL(8'h00), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk), .rst (rst), .bus (if_l)
  );

  always #5 clk = ~clk;

  // Word-level model: q as an integer, a burst as "bits still to send".
  typedef struct {
    int q;
    int left;
    bit done;
  } model_t;

  model_t mm = '{0, 0, 1'b0};
  model_t ml = '{0, 0, 1'b0};
  bit     m_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;
  int done_seen = 0;
  logic [7:0] cap_m = '0;
  logic [7:0] cap_l = '0;

  function automatic model_t step(model_t s, bit r, bit e, logic [2:0] m,
                                  logic [7:0] p, bit si, bit msb);
    model_t n = s;
    int     b = int'(si);
    n.done = 1'b0;
    if (r) begin
      n.q = 0;
      n.left = 0;
      return n;
    end
    if (!e) return n;
    if (m == MODE_CLEAR) begin
      n.q = 0;
      n.left = 0;
    end else if (s.left > 0) begin
      n.q = msb ? (s.q * 2 + b) % 256 : s.q / 2 + b * 128;
      n.left = s.left - 1;
      n.done = (n.left == 0);
    end else begin
      case (m)
        MODE_LOAD:  n.q = int'(p);
        MODE_SHL:   n.q = (s.q * 2 + b) % 256;
        MODE_SHR:   n.q = s.q / 2 + b * 128;
        MODE_ROTL:  n.q = (s.q * 2) % 256 + s.q / 128;
        MODE_ROTR:  n.q = s.q / 2 + (s.q % 2) * 128;
        MODE_BURST: n.left = W;
        default:    ;
      endcase
    end
    return n;
  endfunction

  function automatic int exp_cnt(model_t s);
    return (s.left > 0) ? (W - s.left) : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model with the inputs applied at this edge.
  always @(posedge clk) begin
    mm = step(mm, rst, en, mode, pin, sin, 1'b1);
    ml = step(ml, rst, en, mode, pin, sin, 1'b0);
    if (rst) m_valid = 1'b1;
  end

  // Serial receiver: take sout on every edge that actually shifts a burst bit.
  always @(posedge clk) begin
    if (!rst && en && mode != MODE_CLEAR) begin
      if (if_m.busy) cap_m = {cap_m[6:0], if_m.sout};
      if (if_l.busy) cap_l = {cap_l[6:0], if_l.sout};
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("q_m",    32'(if_m.q),    32'(mm.q));
      chk("busy_m", 32'(if_m.busy), 32'(mm.left > 0));
      chk("done_m", 32'(if_m.done), 32'(mm.done));
      chk("cnt_m",  32'(if_m.cnt),  32'(exp_cnt(mm)));
      chk("sout_m", 32'(if_m.sout), 32'(mm.q / 128));
      chk("q_l",    32'(if_l.q),    32'(ml.q));
      chk("busy_l", 32'(if_l.busy), 32'(ml.left > 0));
      chk("done_l", 32'(if_l.done), 32'(ml.done));
      chk("cnt_l",  32'(if_l.cnt),  32'(exp_cnt(ml)));
      chk("sout_l", 32'(if_l.sout), 32'(ml.q % 2));
      if (if_m.busy) busy_cnt++;
      if (if_m.done || if_l.done) done_seen++;
    end
  end

  // One clock with the given inputs; returns at the following falling edge.
  task automatic cyc(bit r, bit e, logic [2:0] m, logic [7:0] p, bit s);
    rst = r; en = e; mode = m; pin = p; sin = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] op_mode [5] = '{MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_CLEAR};
  bit         op_sin  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] op_exp  [5] = '{8'h4B, 8'h52, 8'h4B, 8'hD2, 8'h00};
  string      op_name [5] = '{"shl", "shr", "rotl", "rotr", "clear"};

  initial begin
    cyc(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0);

    // Reset beats a pending load with en low.
    cyc(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0);
    cyc(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b0);
    chk("rst_q",    32'(if_m.q),    32'h00);
    chk("rst_busy", 32'(if_m.busy), 32'h0);
    chk("rst_done", 32'(if_m.done), 32'h0);
    chk("rst_cnt",  32'(if_m.cnt),  32'h0);

    // Single commands from 0xA5.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0);
      cyc(1'b0, 1'b1, op_mode[i], 8'h00, op_sin[i]);
      chk({op_name[i], "_lit"},   32'(if_m.q), 32'(op_exp[i]));
      chk({op_name[i], "_model"}, 32'(mm.q),   32'(op_exp[i]));
    end

    // Plain burst of 0xA5 on both directions.
    cyc(1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0);
    cap_m = '0; cap_l = '0; busy_cnt = 0;
    cyc(1'b0, 1'b1, MODE_BURST, 8'h00, 1'b0);
    repeat (8) cyc(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("a5_done_m",  32'(if_m.done), 32'h1);
    chk("a5_done_l",  32'(if_l.done), 32'h1);
    chk("a5_q",       32'(if_m.q),    32'h00);
    chk("a5_bits_m",  32'(cap_m),     32'hA5);
    chk("a5_bits_l",  32'(cap_l),     32'hA5);
    chk("a5_busycyc", 32'(busy_cnt),  32'd8);

    // BURST issued in the done cycle is accepted.
    cyc(1'b0, 1'b1, MODE_BURST, 8'h00, 1'b1);
    chk("reburst_busy", 32'(if_m.busy), 32'h1);
    chk("reburst_cnt",  32'(if_m.cnt),  32'h0);
    repeat (8) cyc(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b1);

    // Burst of 0x3C stalled for 3 cycles at cnt=4; LOAD while busy is ignored.
    cyc(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0);
    cap_m = '0; cap_l = '0; busy_cnt = 0;
    cyc(1'b0, 1'b1, MODE_BURST, 8'h00, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0);
    chk("stall_cnt4", 32'(if_m.cnt), 32'd4);
    repeat (3) cyc(1'b0, 1'b0, MODE_LOAD, 8'hFF, 1'b0);
    chk("stall_cnt_hold", 32'(if_m.cnt),  32'd4);
    chk("stall_busy",     32'(if_m.busy), 32'h1);
    repeat (4) cyc(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0);
    chk("stall_done",     32'(if_m.done), 32'h1);
    chk("stall_busycyc",  32'(busy_cnt),  32'd11);
    chk("stall_bits_m",   32'(cap_m),     32'h3C);
    chk("stall_bits_l",   32'(cap_l),     32'h3C);

    // CLEAR at cnt=3 aborts without done; a following burst of ones fills q.
    cyc(1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0);
    done_seen = 0;
    cyc(1'b0, 1'b1, MODE_BURST, 8'h00, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("abort_cnt3", 32'(if_m.cnt), 32'd3);
    cyc(1'b0, 1'b1, MODE_CLEAR, 8'h00, 1'b0);
    chk("abort_q",    32'(if_m.q),    32'h00);
    chk("abort_busy", 32'(if_m.busy), 32'h0);
    repeat (3) cyc(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("abort_nodone", 32'(done_seen), 32'd0);
    cyc(1'b0, 1'b1, MODE_BURST, 8'h00, 1'b1);
    repeat (8) cyc(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b1);
    chk("ones_q_m", 32'(if_m.q), 32'hFF);
    chk("ones_q_l", 32'(if_l.q), 32'hFF);

    // Reset with en low at cnt=5 kills the burst.
    cyc(1'b0, 1'b1, MODE_LOAD, 8'h5A, 1'b0);
    cyc(1'b0, 1'b1, MODE_BURST, 8'h00, 1'b1);
    repeat (5) cyc(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b1);
    chk("midrst_cnt5", 32'(if_m.cnt), 32'd5);
    done_seen = 0;
    cyc(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b1);
    chk("midrst_q",    32'(if_m.q),    32'h00);
    chk("midrst_busy", 32'(if_m.busy), 32'h0);
    chk("midrst_cnt",  32'(if_m.cnt),  32'h0);
    repeat (2) cyc(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    chk("midrst_nodone", 32'(done_seen), 32'd0);

    // Random traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
          3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
